// File: rtl/nf_dm_arbiter_if.sv
// Request/acknowledge bus shared by the data-port masters and the RAM data port.
// The master modport drives a transaction; the slave modport accepts it and returns read data.
interface nf_dm_arbiter_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wd;
  logic        req;
  logic        req_ack;
  logic [31:0] rd;

  modport master (output addr, we, wd, req, input req_ack, rd);
  modport slave  (input addr, we, wd, req, output req_ack, rd);
endinterface

// File: rtl/nf_dm_arbiter.sv
// Round-robin arbiter sharing the dual-port RAM data port between the CPU (m0) and the loader (m1).
// One transaction is in flight at a time: 1-cycle arbitration, then a slave access, then an optional read wait.
module nf_dm_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  nf_dm_arbiter_if.slave  m0,
  nf_dm_arbiter_if.slave  m1,
  nf_dm_arbiter_if.master s
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  state_t      state;
  state_t      state_next;
  logic        owner;
  logic        last;
  logic        ack_q;
  logic [1:0]  lat_cnt;
  logic [31:0] rd0;
  logic [31:0] rd1;

  logic req0_eff;
  logic req1_eff;
  logic grant;
  logic own_req;
  logic own_we;
  logic accept;

  // A master still sees its own registered read ack in this IDLE cycle; its held req must not re-win.
  assign req0_eff = m0.req & ~(ack_q & ~owner);
  assign req1_eff = m1.req & ~(ack_q & owner);
  assign grant    = (req0_eff & req1_eff) ? ~last : req1_eff;
  assign own_req  = owner ? m1.req : m0.req;
  assign own_we   = owner ? m1.we  : m0.we;
  assign accept   = (state == BUSY) & own_req & s.req_ack;

  assign m0.rd = rd0;
  assign m1.rd = rd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req0_eff | req1_eff) state_next = BUSY;
      BUSY: begin
        if (!own_req)    state_next = IDLE;
        else if (accept) state_next = own_we ? IDLE : RESP;
      end
      RESP: if (lat_cnt == 2'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s.addr     = '0;
    s.we       = 1'b0;
    s.wd       = '0;
    s.req      = 1'b0;
    m0.req_ack = 1'b0;
    m1.req_ack = 1'b0;
    if (state == BUSY) begin
      s.addr = owner ? m1.addr : m0.addr;
      s.we   = own_we;
      s.wd   = owner ? m1.wd : m0.wd;
      s.req  = own_req;
    end
    // Writes complete combinationally on accept; reads complete via the registered ack_q.
    m0.req_ack = ~owner & ((accept & own_we) | ack_q);
    m1.req_ack =  owner & ((accept & own_we) | ack_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner   <= 1'b0;
      last    <= 1'b1;
      ack_q   <= 1'b0;
      lat_cnt <= 2'd0;
      rd0     <= '0;
      rd1     <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        IDLE: if (req0_eff | req1_eff) owner <= grant;
        BUSY: begin
          if (accept) begin
            if (own_we) last    <= owner;
            else        lat_cnt <= LAT_INIT;
          end
        end
        RESP: begin
          if (lat_cnt != 2'd0) begin
            lat_cnt <= lat_cnt - 2'd1;
          end else begin
            if (owner) rd1 <= s.rd;
            else       rd0 <= s.rd;
            ack_q <= 1'b1;
            last  <= owner;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nf_dm_arbiter.sv
// Scoreboard bench for nf_dm_arbiter: expected completions are queued as requests are issued
// and matched against each req_ack pulse; a small RAM model with configurable read latency acts as the slave.
module tb_nf_dm_arbiter;

  localparam int RD_LAT = 3;

  typedef struct {
    logic        m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t        sb_q[$];
  logic [31:0] exp_rd_m0 = '0;
  logic [31:0] exp_rd_m1 = '0;

  logic [31:0] mem [0:63];
  logic [63:0] wr_valid = '0;
  logic [31:0] pipe [0:RD_LAT-1];

  nf_dm_arbiter_if m0_bus ();
  nf_dm_arbiter_if m1_bus ();
  nf_dm_arbiter_if s_bus ();

  nf_dm_arbiter #(.RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_bus),
    .m1  (m1_bus),
    .s   (s_bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave RAM: unwritten words read back as A5A5 followed by the low address half.
  always @(posedge clk) begin
    if (s_bus.req && s_bus.req_ack && s_bus.we) begin
      mem[s_bus.addr[7:2]]      <= s_bus.wd;
      wr_valid[s_bus.addr[7:2]] <= 1'b1;
    end
    if (s_bus.req && s_bus.req_ack && !s_bus.we)
      pipe[0] <= wr_valid[s_bus.addr[7:2]] ? mem[s_bus.addr[7:2]] : {16'hA5A5, s_bus.addr[15:0]};
    else
      pipe[0] <= 32'h0BAD0BAD;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign s_bus.rd = pipe[RD_LAT-1];

  task automatic checkOutput(input string tag, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic pushExp(input logic m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    e.m = m; e.we = we; e.addr = addr; e.wd = wd; e.rd = rd;
    sb_q.push_back(e);
  endtask

  // Drives one request on a master, holds it until its ack, optionally checks the latency in cycles.
  task automatic applyStimulus(input logic m, input logic we, input logic [31:0] addr,
                               input logic [31:0] wd, input int exp_lat);
    int start;
    bit done;
    if (m) begin
      m1_bus.addr = addr; m1_bus.we = we; m1_bus.wd = wd; m1_bus.req = 1'b1;
    end else begin
      m0_bus.addr = addr; m0_bus.we = we; m0_bus.wd = wd; m0_bus.req = 1'b1;
    end
    start = cyc;
    done  = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (m ? m1_bus.req_ack : m0_bus.req_ack) begin
        done = 1'b1;
        if (exp_lat >= 0) checkOutput("latency", 96'(cyc - start), 96'(exp_lat));
      end
    end
    if (!done) checkOutput("ack_timeout", 96'd0, 96'd1);
    @(posedge clk); #1;
    if (m) m1_bus.req = 1'b0;
    else   m0_bus.req = 1'b0;
  endtask

  // Scoreboard monitor: every ack must match the oldest expected completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (m0_bus.req_ack || m1_bus.req_ack)) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_ack", {m1_bus.req_ack, m0_bus.req_ack}, 2'b00);
        end else begin
          e = sb_q.pop_front();
          checkOutput("ack_master", {m1_bus.req_ack, m0_bus.req_ack}, e.m ? 2'b10 : 2'b01);
          if (e.we) begin
            checkOutput("wr_bus", {s_bus.addr, s_bus.wd, s_bus.we, s_bus.req},
                        {e.addr, e.wd, 1'b1, 1'b1});
          end else if (e.m) begin
            exp_rd_m1 = e.rd;
          end else begin
            exp_rd_m0 = e.rd;
          end
          checkOutput("rd_m0", m0_bus.rd, exp_rd_m0);
          checkOutput("rd_m1", m1_bus.rd, exp_rd_m1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    m0_bus.addr = 32'h0; m0_bus.we = 1'b0; m0_bus.wd = 32'h0; m0_bus.req = 1'b1;
    m1_bus.addr = 32'h0; m1_bus.we = 1'b0; m1_bus.wd = 32'h0; m1_bus.req = 1'b1;
    s_bus.req_ack = 1'b1;

    // Reset held with both masters requesting: nothing may leak out.
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_outs", {s_bus.req, s_bus.we, s_bus.addr, s_bus.wd,
                                 m0_bus.req_ack, m1_bus.req_ack}, '0);
      checkOutput("reset_rd", {m0_bus.rd, m1_bus.rd}, '0);
    end
    @(posedge clk); #1;
    m0_bus.req = 1'b0; m1_bus.req = 1'b0;
    rst = 1'b0;

    // M0 write then read back the same word.
    pushExp(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1);
    pushExp(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 2 + RD_LAT);

    // Fresh reset, then both masters stream reads: grants must alternate starting with M0.
    rst = 1'b1;
    exp_rd_m0 = '0; exp_rd_m1 = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    pushExp(1'b0, 1'b0, 32'h20, 32'h0, 32'hA5A50020);
    pushExp(1'b1, 1'b0, 32'h30, 32'h0, 32'hA5A50030);
    pushExp(1'b0, 1'b0, 32'h24, 32'h0, 32'hA5A50024);
    pushExp(1'b1, 1'b0, 32'h34, 32'h0, 32'hA5A50034);
    fork
      begin
        applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, 2 + RD_LAT);
        applyStimulus(1'b0, 1'b0, 32'h24, 32'h0, -1);
      end
      begin
        applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, -1);
        applyStimulus(1'b1, 1'b0, 32'h34, 32'h0, -1);
      end
    join

    // M1 abandons its request while the slave stalls; last stays M1, so the next tie goes to M0.
    s_bus.req_ack = 1'b0;
    m1_bus.addr = 32'h40; m1_bus.we = 1'b0; m1_bus.req = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("abort_busy_req", s_bus.req, 1'b1);
    checkOutput("abort_no_ack", {m1_bus.req_ack, m0_bus.req_ack}, 2'b00);
    @(posedge clk); #1;
    m1_bus.req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("abort_idle_req", s_bus.req, 1'b0);
      checkOutput("abort_no_ack", {m1_bus.req_ack, m0_bus.req_ack}, 2'b00);
      @(posedge clk); #1;
    end
    s_bus.req_ack = 1'b1;
    pushExp(1'b0, 1'b1, 32'h44, 32'h11111111, 32'h0);
    pushExp(1'b1, 1'b1, 32'h48, 32'h22222222, 32'h0);
    fork
      applyStimulus(1'b0, 1'b1, 32'h44, 32'h11111111, 1);
      applyStimulus(1'b1, 1'b1, 32'h48, 32'h22222222, -1);
    join

    // Slave stalls two BUSY cycles: bus must hold steady and the ack slips by exactly two.
    s_bus.req_ack = 1'b0;
    pushExp(1'b0, 1'b0, 32'h44, 32'h0, 32'h11111111);
    fork
      applyStimulus(1'b0, 1'b0, 32'h44, 32'h0, 2 + RD_LAT + 2);
      begin
        @(posedge clk);
        repeat (2) begin
          @(negedge clk);
          checkOutput("stall_hold", {s_bus.req, s_bus.addr}, {1'b1, 32'h44});
          @(posedge clk);
        end
        #1 s_bus.req_ack = 1'b1;
      end
    join

    // Reset while a read waits in RESP: the read is dropped and outputs clear.
    m0_bus.addr = 32'h48; m0_bus.we = 1'b0; m0_bus.req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    m0_bus.req = 1'b0;
    exp_rd_m0 = '0; exp_rd_m1 = '0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_resp_outs", {m0_bus.req_ack, m1_bus.req_ack, s_bus.req,
                                    m0_bus.rd, m1_bus.rd}, '0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    repeat (RD_LAT + 2) begin
      @(negedge clk);
      checkOutput("rst_no_ack", {m1_bus.req_ack, m0_bus.req_ack, s_bus.req}, 3'b000);
    end
    @(posedge clk); #1;
    pushExp(1'b1, 1'b0, 32'h48, 32'h0, 32'h22222222);
    applyStimulus(1'b1, 1'b0, 32'h48, 32'h0, 2 + RD_LAT);

    repeat (3) @(posedge clk);
    checkOutput("sb_empty", 96'(sb_q.size()), 96'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
